// File: rtl/greenhouse_climate_fsm_if.sv
// greenhouse_climate_fsm_if: sensor samples, runtime thresholds and actuator outputs of the climate FSM.
interface greenhouse_climate_fsm_if;
    logic        sample_valid;
    logic [15:0] light;
    logic [15:0] solar_th;
    logic [7:0]  solar_temp;
    logic [7:0]  greenhouse_temp;
    logic [7:0]  ambient_temp;
    logic [7:0]  geothermal_temp;
    logic [7:0]  solar_cooldown_th;
    logic [7:0]  solar_heatup_th;
    logic [7:0]  greenhouse_cooldown_th;
    logic [7:0]  greenhouse_heatup_th;
    logic [7:0]  ambient_cooldown_th;
    logic [7:0]  ambient_heatup_th;
    logic [7:0]  geothermal_cooldown_th;
    logic [7:0]  geothermal_heatup_th;
    logic [1:0]  state;
    logic [1:0]  active_source;
    logic        pump_solar;
    logic        pump_geo;
    logic        fan_ambient;
    logic        stale;

    modport master (
        output sample_valid, light, solar_th,
        output solar_temp, greenhouse_temp, ambient_temp, geothermal_temp,
        output solar_cooldown_th, solar_heatup_th, greenhouse_cooldown_th, greenhouse_heatup_th,
        output ambient_cooldown_th, ambient_heatup_th, geothermal_cooldown_th, geothermal_heatup_th,
        input  state, active_source, pump_solar, pump_geo, fan_ambient, stale
    );

    modport slave (
        input  sample_valid, light, solar_th,
        input  solar_temp, greenhouse_temp, ambient_temp, geothermal_temp,
        input  solar_cooldown_th, solar_heatup_th, greenhouse_cooldown_th, greenhouse_heatup_th,
        input  ambient_cooldown_th, ambient_heatup_th, geothermal_cooldown_th, geothermal_heatup_th,
        output state, active_source, pump_solar, pump_geo, fan_ambient, stale
    );
endinterface

// File: rtl/greenhouse_climate_fsm.sv
// greenhouse_climate_fsm: heat/cool/idle decision with source selection, dwell rate limiting and sample watchdog.
module greenhouse_climate_fsm #(
    parameter int MIN_DWELL = 1000,
    parameter int TIMEOUT   = 50000000,
    parameter int HYST      = 2
) (
    input logic clk,
    input logic rst,
    greenhouse_climate_fsm_if.slave bus
);
    localparam logic [1:0] S_IDLE    = 2'd0;
    localparam logic [1:0] S_HEAT    = 2'd1;
    localparam logic [1:0] S_COOL    = 2'd2;
    localparam logic [1:0] SRC_NONE  = 2'd0;
    localparam logic [1:0] SRC_SOLAR = 2'd1;
    localparam logic [1:0] SRC_GEO   = 2'd2;
    localparam logic [1:0] SRC_AMB   = 2'd3;
    localparam int DW = MIN_DWELL > 0 ? $clog2(MIN_DWELL + 1) : 1;
    localparam int WW = TIMEOUT > 0 ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [DW-1:0] DWELL_LOAD = DW'(MIN_DWELL);
    localparam logic [WW-1:0] WD_LIMIT = WW'(TIMEOUT);
    localparam logic [WW:0] WD_LIMIT_X = (WW + 1)'(TIMEOUT);
    localparam logic signed [9:0] HYST10 = 10'(HYST);

    function automatic logic signed [9:0] sx(input logic [7:0] v);
        return {{2{v[7]}}, v};
    endfunction

    function automatic logic [2:0] decode(input logic [1:0] s);
        return {s == SRC_AMB, s == SRC_GEO, s == SRC_SOLAR};
    endfunction

    logic signed [9:0] w_gh, w_sol, w_geo, w_amb;
    logic signed [9:0] w_gh_heat, w_gh_cool;
    logic w_light_ok;
    logic w_heat_sol, w_heat_geo, w_heat_amb;
    logic w_cool_sol, w_cool_geo, w_cool_amb;
    logic [1:0] w_heat_src, w_cool_src, w_next_state, w_next_src;
    logic w_change, w_accept, w_wd_expire;
    logic [WW:0] w_wd_inc;

    logic [1:0]    r_state, r_src;
    logic [2:0]    r_act;
    logic          r_stale;
    logic [DW-1:0] r_dwell;
    logic [WW-1:0] r_wd;

    assign w_gh       = sx(bus.greenhouse_temp);
    assign w_sol      = sx(bus.solar_temp);
    assign w_geo      = sx(bus.geothermal_temp);
    assign w_amb      = sx(bus.ambient_temp);
    assign w_gh_heat  = sx(bus.greenhouse_heatup_th);
    assign w_gh_cool  = sx(bus.greenhouse_cooldown_th);
    assign w_light_ok = bus.light >= bus.solar_th;

    assign w_heat_sol = w_light_ok && w_sol > w_gh && w_sol >= sx(bus.solar_heatup_th);
    assign w_heat_geo = w_geo > w_gh && w_geo >= sx(bus.geothermal_heatup_th);
    assign w_heat_amb = w_amb > w_gh && w_amb >= sx(bus.ambient_heatup_th);
    assign w_cool_sol = !w_light_ok && w_sol < w_gh && w_sol <= sx(bus.solar_cooldown_th);
    assign w_cool_geo = w_geo < w_gh && w_geo <= sx(bus.geothermal_cooldown_th);
    assign w_cool_amb = w_amb < w_gh && w_amb <= sx(bus.ambient_cooldown_th);

    assign w_heat_src = w_heat_sol ? SRC_SOLAR : w_heat_geo ? SRC_GEO : w_heat_amb ? SRC_AMB : SRC_NONE;
    assign w_cool_src = w_cool_amb ? SRC_AMB : w_cool_geo ? SRC_GEO : w_cool_sol ? SRC_SOLAR : SRC_NONE;

    // HEAT is tested first so it wins when the greenhouse thresholds overlap.
    assign w_next_state = r_state == S_IDLE ? (w_gh < w_gh_heat ? S_HEAT : w_gh > w_gh_cool ? S_COOL : S_IDLE)
                        : r_state == S_HEAT ? (w_gh >= w_gh_heat + HYST10 ? S_IDLE : S_HEAT)
                        : (w_gh <= w_gh_cool - HYST10 ? S_IDLE : S_COOL);
    assign w_next_src = w_next_state == S_HEAT ? w_heat_src : w_next_state == S_COOL ? w_cool_src : SRC_NONE;

    assign w_change    = {w_next_state, w_next_src} != {r_state, r_src};
    assign w_accept    = bus.sample_valid && w_change && r_dwell == '0;
    assign w_wd_inc    = {1'b0, r_wd} + 1'b1;
    assign w_wd_expire = !bus.sample_valid && w_wd_inc >= WD_LIMIT_X;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_src   <= SRC_NONE;
            r_act   <= '0;
            r_stale <= 1'b0;
            r_dwell <= '0;
            r_wd    <= '0;
        end else begin
            r_wd <= bus.sample_valid ? '0 : (r_wd == WD_LIMIT ? r_wd : w_wd_inc[WW-1:0]);
            if (w_wd_expire) begin
                r_stale <= 1'b1;
                r_state <= S_IDLE;
                r_src   <= SRC_NONE;
                r_act   <= '0;
                r_dwell <= '0;
            end else begin
                if (bus.sample_valid)
                    r_stale <= 1'b0;
                if (w_accept) begin
                    r_state <= w_next_state;
                    r_src   <= w_next_src;
                    r_act   <= decode(w_next_src);
                    r_dwell <= DWELL_LOAD;
                end else if (r_dwell != '0) begin
                    r_dwell <= r_dwell - 1'b1;
                end
            end
        end
    end

    assign bus.state         = r_state;
    assign bus.active_source = r_src;
    assign bus.pump_solar    = r_act[0];
    assign bus.pump_geo      = r_act[1];
    assign bus.fan_ambient   = r_act[2];
    assign bus.stale         = r_stale;
endmodule

// File: tb/tb_greenhouse_climate_fsm.sv
// tb_greenhouse_climate_fsm: directed scenarios with a queue of expected outputs checked one cycle after each drive.
module tb_greenhouse_climate_fsm;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int checks = 0;
    int errors = 0;

    typedef struct {
        string      tag;
        logic [1:0] st;
        logic [1:0] src;
        logic       stl;
    } exp_t;
    exp_t sb[$];

    greenhouse_climate_fsm_if bus ();

    greenhouse_climate_fsm #(.MIN_DWELL(4), .TIMEOUT(20), .HYST(2)) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input string what, input logic [3:0] obs, input logic [3:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s %s observed %0h expected %0h", tag, what, obs, exp);
        end
    endtask

    task automatic env(input int sol, input int geo, input int amb, input int lt);
        bus.solar_temp      = 8'(sol);
        bus.geothermal_temp = 8'(geo);
        bus.ambient_temp    = 8'(amb);
        bus.light           = 16'(lt);
    endtask

    task automatic step(input bit sv, input int gh, input string tag,
                        input logic [1:0] st, input logic [1:0] src, input logic stl);
        exp_t e;
        @(negedge clk);
        bus.sample_valid    = sv;
        bus.greenhouse_temp = 8'(gh);
        e.tag = tag;
        e.st  = st;
        e.src = src;
        e.stl = stl;
        sb.push_back(e);
        @(posedge clk);
        #1;
        e = sb.pop_front();
        chk(e.tag, "state", {2'b0, bus.state}, {2'b0, e.st});
        chk(e.tag, "source", {2'b0, bus.active_source}, {2'b0, e.src});
        chk(e.tag, "actuators", {1'b0, bus.fan_ambient, bus.pump_geo, bus.pump_solar},
            {1'b0, e.src == 2'd3, e.src == 2'd2, e.src == 2'd1});
        chk(e.tag, "stale", {3'b0, bus.stale}, {3'b0, e.stl});
        bus.sample_valid = 1'b0;
    endtask

    task automatic idle(input int n, input string tag, input logic [1:0] st, input logic [1:0] src, input logic stl);
        for (int i = 0; i < n; i++)
            step(1'b0, 25, tag, st, src, stl);
    endtask

    initial begin
        bus.sample_valid           = 1'b0;
        bus.greenhouse_temp        = 8'd25;
        bus.solar_th               = 16'd2550;
        bus.solar_cooldown_th      = 8'd35;
        bus.greenhouse_cooldown_th = 8'd35;
        bus.ambient_cooldown_th    = 8'd35;
        bus.geothermal_cooldown_th = 8'd35;
        bus.solar_heatup_th        = 8'd16;
        bus.greenhouse_heatup_th   = 8'd16;
        bus.ambient_heatup_th      = 8'd16;
        bus.geothermal_heatup_th   = 8'd16;
        env(40, 12, 5, 3000);
        step(1'b0, 25, "reset", 2'd0, 2'd0, 1'b0);
        rst = 1'b0;

        step(1'b1, 10, "solar_heat", 2'd1, 2'd1, 1'b0);
        idle(4, "solar_hold", 2'd1, 2'd1, 1'b0);
        step(1'b1, 16, "hyst16", 2'd1, 2'd1, 1'b0);
        step(1'b1, 17, "hyst17", 2'd1, 2'd1, 1'b0);
        step(1'b1, 18, "hyst18_exit", 2'd0, 2'd0, 1'b0);
        idle(4, "idle_wait", 2'd0, 2'd0, 1'b0);

        env(40, 20, 5, 2000);
        step(1'b1, 10, "geo_fallback", 2'd1, 2'd2, 1'b0);
        idle(4, "geo_hold", 2'd1, 2'd2, 1'b0);
        step(1'b1, 18, "geo_exit", 2'd0, 2'd0, 1'b0);
        idle(4, "idle_wait2", 2'd0, 2'd0, 1'b0);

        env(50, 50, 20, 2000);
        step(1'b1, 40, "cool_amb", 2'd2, 2'd3, 1'b0);
        idle(1, "cool_hold", 2'd2, 2'd3, 1'b0);
        step(1'b1, 30, "dwell_reject", 2'd2, 2'd3, 1'b0);
        idle(2, "cool_hold2", 2'd2, 2'd3, 1'b0);
        step(1'b1, 30, "dwell_accept", 2'd0, 2'd0, 1'b0);
        idle(4, "idle_wait3", 2'd0, 2'd0, 1'b0);

        env(40, 12, 5, 3000);
        step(1'b1, 10, "wd_heat", 2'd1, 2'd1, 1'b0);
        idle(19, "wd_pre", 2'd1, 2'd1, 1'b0);
        idle(1, "wd_expire", 2'd0, 2'd0, 1'b1);
        idle(1, "wd_saturate", 2'd0, 2'd0, 1'b1);
        step(1'b1, 25, "wd_clear", 2'd0, 2'd0, 1'b0);
        idle(19, "wd_pre2", 2'd0, 2'd0, 1'b0);
        step(1'b1, 25, "wd_sample_wins", 2'd0, 2'd0, 1'b0);
        idle(1, "wd_after", 2'd0, 2'd0, 1'b0);

        step(1'b1, 10, "pre_reset_heat", 2'd1, 2'd1, 1'b0);
        rst = 1'b1;
        step(1'b0, 25, "mid_reset", 2'd0, 2'd0, 1'b0);
        rst = 1'b0;
        step(1'b1, 10, "post_reset_heat", 2'd1, 2'd1, 1'b0);

        rst = 1'b1;
        step(1'b0, 25, "reset2", 2'd0, 2'd0, 1'b0);
        rst = 1'b0;
        bus.greenhouse_heatup_th   = 8'd30;
        bus.greenhouse_cooldown_th = 8'd20;
        step(1'b1, 25, "heat_wins", 2'd1, 2'd1, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
